// File: rtl/fifo_rd_arbiter.sv
// Round-robin, burst-bounded scheduler for one async-FIFO read port; returns each popped word
// with its requester tag. Optional per-requester saturating pop counters when ARB_STATS_EN is defined.
module fifo_rd_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int PIPE_READ  = 0,
   parameter int BURST_MAX  = 4,
   parameter int STALL_MAX  = 8,
   parameter int SOFT_RESET = 0
) (
   input  logic                       rclk,
   input  logic                       hw_rst_n,
   input  logic                       sw_rst,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         gnt,
   input  logic                       rdempty,
   output logic                       rinc,
   input  logic [DATA_WIDTH-1:0]      rdata,
   output logic                       rvalid,
   output logic [$clog2(NUM_REQ)-1:0] rtag,
   output logic [DATA_WIDTH-1:0]      rdata_out,
   output logic                       busy
`ifdef ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]      pop_cnt
`endif
);

   localparam int               TAG_W    = $clog2(NUM_REQ);
   localparam logic             SRST_EN  = (SOFT_RESET == 1) || (SOFT_RESET == 3);
   localparam logic             USE_S1   = (PIPE_READ != 0);
   localparam logic [TAG_W:0]   NREQ_W   = (TAG_W+1)'(NUM_REQ);
   localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NUM_REQ - 1);
   localparam logic [4:0]       BURST_W  = 5'(BURST_MAX);
   localparam logic [7:0]       STALL_W  = 8'(STALL_MAX);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [TAG_W-1:0]      owner_q, owner_d;
   logic [TAG_W-1:0]      last_owner_q, last_owner_d;
   logic [4:0]            burst_cnt_q, burst_cnt_d;
   logic [7:0]            stall_cnt_q, stall_cnt_d;
   logic [1:0]            vld_q;
   logic [TAG_W-1:0]      tag0_q, tag1_q;
   logic                  rvalid_q;
   logic [TAG_W-1:0]      rtag_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  srst_s;
   logic                  sel_found_s;
   logic [TAG_W-1:0]      sel_idx_s;
   logic                  fin_vld_s;
   logic [TAG_W-1:0]      fin_tag_s;
   logic                  tag_busy_s;

   assign srst_s = SRST_EN & sw_rst;

   // Round-robin search: first active requester after last_owner, wrapping.
   always_comb begin
      logic [TAG_W:0] cand_w;
      logic           hit;
      sel_found_s = 1'b0;
      sel_idx_s   = '0;
      cand_w      = '0;
      hit         = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_w      = {1'b0, last_owner_q} + (TAG_W+1)'(k);
         cand_w      = (cand_w >= NREQ_W) ? (cand_w - NREQ_W) : cand_w;
         hit         = ~sel_found_s & req[cand_w[TAG_W-1:0]];
         sel_idx_s   = hit ? cand_w[TAG_W-1:0] : sel_idx_s;
         sel_found_s = sel_found_s | hit;
      end
   end

   // Next-state: arbitrate in IDLE, count pops/stalls and release the grant in BURST.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_found_s && !rdempty) begin
               state_d     = ST_BURST;
               owner_d     = sel_idx_s;
               burst_cnt_d = 5'd0;
               stall_cnt_d = 8'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (!req[owner_q]) begin
               state_d      = ST_IDLE;
               last_owner_d = owner_q;
            end else if (!rdempty) begin
               burst_cnt_d = burst_cnt_q + 5'd1;
               stall_cnt_d = 8'd0;
               if (burst_cnt_d == BURST_W) begin
                  state_d      = ST_IDLE;
                  last_owner_d = owner_q;
               end else begin
                  state_d = ST_BURST;
               end
            end else begin
               stall_cnt_d = stall_cnt_q + 8'd1;
               if (stall_cnt_d == STALL_W) begin
                  state_d      = ST_IDLE;
                  last_owner_d = owner_q;
               end else begin
                  state_d = ST_BURST;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs: pops only while bursting and the FIFO has data, so no underflow is possible.
   always_comb begin
      rinc = 1'b0;
      case (state_q)
         ST_IDLE:  rinc = 1'b0;
         ST_BURST: rinc = req[owner_q] & ~rdempty;
         default:  rinc = 1'b0;
      endcase
      gnt  = rinc ? (ONE_HOT0 << owner_q) : '0;
      busy = (state_q == ST_BURST) | tag_busy_s;
   end

   // FSM and arbitration state registers.
   always_ff @(posedge rclk or negedge hw_rst_n) begin
      if (!hw_rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         last_owner_q <= LAST_IDX;
         burst_cnt_q  <= 5'd0;
         stall_cnt_q  <= 8'd0;
      end else if (srst_s) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         last_owner_q <= LAST_IDX;
         burst_cnt_q  <= 5'd0;
         stall_cnt_q  <= 8'd0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   // Stage 1 only participates when the memory read is pipelined.
   assign fin_vld_s  = USE_S1 ? vld_q[1] : vld_q[0];
   assign fin_tag_s  = USE_S1 ? tag1_q : tag0_q;
   assign tag_busy_s = USE_S1 ? (|vld_q) : vld_q[0];

   // Tag pipeline and registered return path; return data holds between valid beats.
   always_ff @(posedge rclk or negedge hw_rst_n) begin
      if (!hw_rst_n) begin
         vld_q    <= 2'b00;
         tag0_q   <= '0;
         tag1_q   <= '0;
         rvalid_q <= 1'b0;
         rtag_q   <= '0;
         rdata_q  <= '0;
      end else if (srst_s) begin
         vld_q    <= 2'b00;
         tag0_q   <= '0;
         tag1_q   <= '0;
         rvalid_q <= 1'b0;
         rtag_q   <= '0;
         rdata_q  <= '0;
      end else begin
         vld_q    <= {vld_q[0], rinc};
         tag0_q   <= owner_q;
         tag1_q   <= tag0_q;
         rvalid_q <= fin_vld_s;
         if (fin_vld_s) begin
            rdata_q <= rdata;
            rtag_q  <= fin_tag_s;
         end else begin
            rdata_q <= rdata_q;
            rtag_q  <= rtag_q;
         end
      end
   end

   assign rvalid    = rvalid_q;
   assign rtag      = rtag_q;
   assign rdata_out = rdata_q;

`ifdef ARB_STATS_EN
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
      logic [15:0] cnt_q;
      // Saturating pop counter for requester g.
      always_ff @(posedge rclk or negedge hw_rst_n) begin
         if (!hw_rst_n) begin
            cnt_q <= 16'd0;
         end else if (srst_s) begin
            cnt_q <= 16'd0;
         end else if (gnt[g] && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
         end else begin
            cnt_q <= cnt_q;
         end
      end
      assign pop_cnt[16*g +: 16] = cnt_q;
   end
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: u0 uses a 1-cycle read, u1 a pipelined 2-cycle read.
`timescale 1ns/1ps
module tb_fifo_rd_arbiter;

   logic rclk = 1'b0;
   always #5 rclk = ~rclk;

   logic        rst0_n, sw_rst0, rdempty0, rinc0, rvalid0, busy0;
   logic [3:0]  req0, gnt0;
   logic [1:0]  rtag0;
   logic [31:0] rdata0, rdata_out0;
   logic        rst1_n, sw_rst1, rdempty1, rinc1, rvalid1, busy1;
   logic [3:0]  req1, gnt1;
   logic [1:0]  rtag1;
   logic [31:0] rdata1, rdata_out1, s1;
`ifdef ARB_STATS_EN
   logic [63:0] pop_cnt0, pop_cnt1;
`endif

   int unsigned rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;
   int          errors = 0, checks = 0, nret = 0, pj;
   logic [3:0]  eg;

   assign rdempty0 = (rd0 == wr0);
   assign rdempty1 = (rd1 == wr1);

   // FIFO stand-ins: word k of u0 is D000_0000|k, of u1 is E000_0000|k.
   always @(posedge rclk) begin
      if (rinc0) begin
         rdata0 <= 32'hD000_0000 | rd0;
         rd0    <= rd0 + 32'd1;
      end
      if (rinc1) begin
         s1  <= 32'hE000_0000 | rd1;
         rd1 <= rd1 + 32'd1;
      end
      rdata1 <= s1;
   end

   fifo_rd_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .PIPE_READ(0), .BURST_MAX(4),
                     .STALL_MAX(8), .SOFT_RESET(1)) u0 (
      .rclk(rclk), .hw_rst_n(rst0_n), .sw_rst(sw_rst0), .req(req0), .gnt(gnt0),
      .rdempty(rdempty0), .rinc(rinc0), .rdata(rdata0), .rvalid(rvalid0), .rtag(rtag0),
      .rdata_out(rdata_out0), .busy(busy0)
`ifdef ARB_STATS_EN
      , .pop_cnt(pop_cnt0)
`endif
   );

   fifo_rd_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .PIPE_READ(1), .BURST_MAX(4),
                     .STALL_MAX(8), .SOFT_RESET(0)) u1 (
      .rclk(rclk), .hw_rst_n(rst1_n), .sw_rst(sw_rst1), .req(req1), .gnt(gnt1),
      .rdempty(rdempty1), .rinc(rinc1), .rdata(rdata1), .rvalid(rvalid1), .rtag(rtag1),
      .rdata_out(rdata_out1), .busy(busy1)
`ifdef ARB_STATS_EN
      , .pop_cnt(pop_cnt1)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst0_n = 1'b0; rst1_n = 1'b0; sw_rst0 = 1'b0; sw_rst1 = 1'b0;
      req0 = 4'b0000; req1 = 4'b0000;
      repeat (2) @(negedge rclk);
      #1;
      chk("rst_rinc", 64'(rinc0), 64'h0);
      chk("rst_gnt", 64'(gnt0), 64'h0);
      chk("rst_rvalid", 64'(rvalid0), 64'h0);
      chk("rst_busy", 64'(busy0), 64'h0);
      chk("rst_rtag", 64'(rtag0), 64'h0);
      chk("rst_rdata_out", 64'(rdata_out0), 64'h0);

      // Single requester, three words then empty: bubble, 3 pops, 8 stall cycles.
      @(negedge rclk); rst0_n = 1'b1; rst1_n = 1'b1; req0 = 4'b0001; wr0 = 32'd3; #1;
      chk("t1_bubble", 64'(rinc0), 64'h0);
      @(negedge rclk); #1;
      chk("t1_pop1_rinc", 64'(rinc0), 64'h1);
      chk("t1_pop1_gnt", 64'(gnt0), 64'h1);
      @(negedge rclk); #1;
      chk("t1_pop2_rinc", 64'(rinc0), 64'h1);
      chk("t1_pop2_rvalid", 64'(rvalid0), 64'h0);
      chk("t1_pop2_busy", 64'(busy0), 64'h1);
      @(negedge rclk); #1;
      chk("t1_pop3_rinc", 64'(rinc0), 64'h1);
      chk("t1_ret0_valid", 64'(rvalid0), 64'h1);
      chk("t1_ret0_data", 64'(rdata_out0), 64'hD000_0000);
      chk("t1_ret0_tag", 64'(rtag0), 64'h0);
      @(negedge rclk); #1;
      chk("t1_empty_rinc", 64'(rinc0), 64'h0);
      chk("t1_empty_gnt", 64'(gnt0), 64'h0);
      chk("t1_ret1_data", 64'(rdata_out0), 64'hD000_0001);
      @(negedge rclk); #1;
      chk("t1_ret2_valid", 64'(rvalid0), 64'h1);
      chk("t1_ret2_data", 64'(rdata_out0), 64'hD000_0002);
      @(negedge rclk); #1;
      chk("t1_hold_valid", 64'(rvalid0), 64'h0);
      chk("t1_hold_data", 64'(rdata_out0), 64'hD000_0002);
      for (int k = 0; k < 5; k++) begin
         @(negedge rclk); #1;
         chk("t1_stall_busy", 64'(busy0), 64'h1);
         chk("t1_stall_rinc", 64'(rinc0), 64'h0);
      end
      // Eighth stall releases the grant: a new word must see an IDLE bubble first.
      @(negedge rclk); wr0 = 32'd4; #1;
      chk("t1_release_rinc", 64'(rinc0), 64'h0);
      chk("t1_release_busy", 64'(busy0), 64'h0);
      @(negedge rclk); #1;
      chk("t1_regrant_gnt", 64'(gnt0), 64'h1);
      @(negedge rclk); req0 = 4'b0000; #1;
      chk("t1_drop_rinc", 64'(rinc0), 64'h0);
      @(negedge rclk); #1;
      chk("t1_ret3_data", 64'(rdata_out0), 64'hD000_0003);
      chk("t1_after_busy", 64'(busy0), 64'h0);

      // Empty FIFO with every request high: no pops, stays idle.
      for (int k = 0; k < 5; k++) begin
         @(negedge rclk); req0 = 4'b1111; #1;
         chk("t3_rinc", 64'(rinc0), 64'h0);
         chk("t3_gnt", 64'(gnt0), 64'h0);
         chk("t3_busy", 64'(busy0), 64'h0);
      end

      // Soft reset restores last_owner = 3, so the next round starts at requester 0.
      @(negedge rclk); req0 = 4'b0000; sw_rst0 = 1'b1; #1;
      chk("srst_busy", 64'(busy0), 64'h0);

      // All four requesters, 20 words: bursts 0,1,2,3,0 of 4 pops, one bubble each.
      @(negedge rclk); sw_rst0 = 1'b0; req0 = 4'b1111; wr0 = rd0 + 32'd20;
      for (int j = 0; j < 28; j++) begin
         if (j > 0) @(negedge rclk);
         #1;
         eg = ((j % 5) == 0 || j > 24) ? 4'b0000 : (4'b0001 << ((j / 5) % 4));
         chk("t2_gnt", 64'(gnt0), 64'(eg));
         chk("t2_rinc", 64'(rinc0), 64'(eg != 4'b0000));
         pj = j - 2;
         if (pj >= 0 && (pj % 5) != 0 && pj <= 24) begin
            nret++;
            chk("t2_rvalid", 64'(rvalid0), 64'h1);
            chk("t2_rtag", 64'(rtag0), 64'((pj / 5) % 4));
            chk("t2_rdata", 64'(rdata_out0), 64'(32'hD000_0004 + 32'((pj / 5) * 4 + (pj % 5) - 1)));
         end else begin
            chk("t2_rvalid_gap", 64'(rvalid0), 64'h0);
         end
      end
      chk("t2_return_count", 64'(nret), 64'd20);

      // Owner 2 drops its request after two pops; requester 3 wins next.
      @(negedge rclk); req0 = 4'b1100; wr0 = rd0 + 32'd10; #1;
      chk("t4_bubble", 64'(rinc0), 64'h0);
      @(negedge rclk); #1;
      chk("t4_pop1_gnt", 64'(gnt0), 64'h4);
      @(negedge rclk); #1;
      chk("t4_pop2_gnt", 64'(gnt0), 64'h4);
      @(negedge rclk); req0 = 4'b1000; #1;
      chk("t4_drop_rinc", 64'(rinc0), 64'h0);
      chk("t4_drop_gnt", 64'(gnt0), 64'h0);
      chk("t4_ret_tag", 64'(rtag0), 64'h2);
      chk("t4_ret_data", 64'(rdata_out0), 64'hD000_0018);
      @(negedge rclk); #1;
      chk("t4_idle_rinc", 64'(rinc0), 64'h0);
      chk("t4_ret2_data", 64'(rdata_out0), 64'hD000_0019);
      @(negedge rclk); #1;
      chk("t4_next_gnt", 64'(gnt0), 64'h8);
      @(negedge rclk); req0 = 4'b0000; #1;
      chk("t4_stop_rinc", 64'(rinc0), 64'h0);
      @(negedge rclk); #1;
      chk("t4_ret3_valid", 64'(rvalid0), 64'h1);
      chk("t4_ret3_tag", 64'(rtag0), 64'h3);
      chk("t4_ret3_data", 64'(rdata_out0), 64'hD000_001A);

`ifdef ARB_STATS_EN
      @(negedge rclk); sw_rst0 = 1'b1;
      @(negedge rclk); sw_rst0 = 1'b0; req0 = 4'b0010; wr0 = rd0 + 32'd5;
      repeat (7) @(negedge rclk);
      req0 = 4'b0000;
      repeat (3) @(negedge rclk);
      #1;
      chk("stats_five", pop_cnt0, {16'd0, 16'd0, 16'd5, 16'd0});
      @(negedge rclk); sw_rst0 = 1'b1;
      @(negedge rclk); sw_rst0 = 1'b0; #1;
      chk("stats_clear", pop_cnt0, 64'h0);
`endif

      // Pipelined read: three pops, hardware reset for one cycle before the second return.
      @(negedge rclk); req1 = 4'b0001; wr1 = 32'd3; #1;
      chk("t5_bubble", 64'(rinc1), 64'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge rclk); #1;
         chk("t5_pop_rinc", 64'(rinc1), 64'h1);
         chk("t5_no_early_ret", 64'(rvalid1), 64'h0);
      end
      @(negedge rclk); #1;
      chk("t5_ret0_valid", 64'(rvalid1), 64'h1);
      chk("t5_ret0_data", 64'(rdata_out1), 64'hE000_0000);
      chk("t5_ret0_tag", 64'(rtag1), 64'h0);
      req1 = 4'b0000; rst1_n = 1'b0;
      @(negedge rclk); rst1_n = 1'b1; #1;
      chk("t5_rst_valid", 64'(rvalid1), 64'h0);
      chk("t5_rst_busy", 64'(busy1), 64'h0);
      chk("t5_rst_rtag", 64'(rtag1), 64'h0);
      chk("t5_rst_data", 64'(rdata_out1), 64'h0);
      for (int k = 0; k < 2; k++) begin
         @(negedge rclk); #1;
         chk("t5_no_return", 64'(rvalid1), 64'h0);
         chk("t5_idle_busy", 64'(busy1), 64'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
